// File: rtl/disp_pkg.sv
// Shared types and constants for the display autorange front end.
// Holds the FSM state type and the decimal display-limit helpers.
package disp_pkg;

  typedef enum logic {
    IDLE,
    SCALE
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  // A minus sign steals one digit from the display.
  function automatic longint unsigned lim_of(input int digits,
                                             input logic neg);
    return pow10(neg ? digits - 1 : digits) - 64'd1;
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Free-running display update period counter.
// tick is high for one cycle at count PERIOD-1; clr restarts the period.
module disp_tick_gen #(
  parameter int PERIOD = 10
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr || tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/disp_autorange.sv
// Samples a channel, takes |value|, and drops fraction digits
// one per cycle until it fits the display; saturates on overflow.
module disp_autorange
  import disp_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int UPDATE_MS   = 100,
  parameter int NCH         = 4,
  parameter int DW          = 32,
  parameter int FRAC_DIGITS = 0,
  parameter int DIGITS      = 6
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NCH*DW-1:0]      ch_data,
  input  logic [$clog2(NCH)-1:0] ch_sel,
  input  logic                   signed_mode,
  input  logic                   hold,
  input  logic                   sample_now,
  output logic [31:0]            data,
  output logic [DIGITS-1:0]      point,
  output logic                   en,
  output logic                   sign,
  output logic                   ovf,
  output logic                   upd
);

  localparam int P  = CLK_FREQ / 1000 * UPDATE_MS;
  localparam int SW = $clog2(NCH);
  localparam int FW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (DW > 64) ? DW : 64;
  localparam logic [CW-1:0] LIM_POS = CW'(lim_of(DIGITS, 1'b0));
  localparam logic [CW-1:0] LIM_NEG = CW'(lim_of(DIGITS, 1'b1));

  state_t          state;
  state_t          state_nxt;
  logic            tick;
  logic            trigger;
  logic [DW-1:0]   word;
  logic [DW-1:0]   mag;
  logic [DW-1:0]   mag_div;
  logic [CW-1:0]   mag_ext;
  logic [CW-1:0]   lim;
  logic [FW-1:0]   f;
  logic            neg;
  logic            over;
  logic            load;
  logic            do_div;
  logic            do_commit;

  disp_tick_gen #(
    .PERIOD(P)
  ) u_tick (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr    (sample_now),
    .tick   (tick)
  );

  // Out-of-range selects fall through to channel 0.
  always_comb begin
    word = ch_data[DW-1:0];
    for (int i = 1; i < NCH; i++) begin
      if (ch_sel == SW'(i)) word = ch_data[i*DW +: DW];
    end
  end

  assign trigger = (tick | sample_now) & ~hold & (state == IDLE);
  assign mag_ext = CW'(mag);
  assign lim     = neg ? LIM_NEG : LIM_POS;
  assign over    = mag_ext > lim;
  assign mag_div = mag / DW'(10);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (trigger) state_nxt = SCALE;
      SCALE: if (!(over && f != '0)) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    do_div    = 1'b0;
    do_commit = 1'b0;
    unique case (state)
      IDLE:  load = trigger;
      SCALE: begin
        if (over && f != '0) do_div = 1'b1;
        else do_commit = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mag   <= '0;
      f     <= '0;
      neg   <= 1'b0;
      data  <= '0;
      point <= '0;
      en    <= 1'b0;
      sign  <= 1'b0;
      ovf   <= 1'b0;
      upd   <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (load) begin
        neg <= signed_mode & word[DW-1];
        mag <= (signed_mode & word[DW-1]) ? -word : word;
        f   <= FW'(FRAC_DIGITS);
      end
      if (do_div) begin
        mag <= mag_div;
        f   <= f - FW'(1);
      end
      if (do_commit) begin
        data  <= over ? 32'(lim) : 32'(mag_ext);
        ovf   <= over;
        sign  <= neg & (mag != '0);
        point <= (f == '0) ? '0 : (DIGITS'(1) << f);
        en    <= 1'b1;
        upd   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_autorange.sv
// Randomized bench for disp_autorange: three instances (FRAC 0/3/5)
// compared cycle by cycle against a behavioural scoreboard model.
module tb_disp_autorange;

  localparam int P = 10;
  localparam int DIG = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ab, rst_c, hold, sample_now, signed_mode;
  logic [1:0]  ch_sel;
  logic [31:0] wab [4];
  logic [39:0] wc  [4];
  logic [127:0] ch_ab;
  logic [159:0] ch_c;

  assign ch_ab = {wab[3], wab[2], wab[1], wab[0]};
  assign ch_c  = {wc[3], wc[2], wc[1], wc[0]};

  logic [31:0] data_a, data_b, data_c;
  logic [5:0]  point_a, point_b, point_c;
  logic        en_a, en_b, en_c, sign_a, sign_b, sign_c;
  logic        ovf_a, ovf_b, ovf_c, upd_a, upd_b, upd_c;

  disp_autorange #(.CLK_FREQ(1000), .UPDATE_MS(10), .NCH(4), .DW(32),
                   .FRAC_DIGITS(0), .DIGITS(DIG)) u_a (
    .sys_clk(clk), .sys_rst(rst_ab), .ch_data(ch_ab), .ch_sel(ch_sel),
    .signed_mode(signed_mode), .hold(hold), .sample_now(sample_now),
    .data(data_a), .point(point_a), .en(en_a), .sign(sign_a),
    .ovf(ovf_a), .upd(upd_a));

  disp_autorange #(.CLK_FREQ(1000), .UPDATE_MS(10), .NCH(4), .DW(32),
                   .FRAC_DIGITS(3), .DIGITS(DIG)) u_b (
    .sys_clk(clk), .sys_rst(rst_ab), .ch_data(ch_ab), .ch_sel(ch_sel),
    .signed_mode(signed_mode), .hold(hold), .sample_now(sample_now),
    .data(data_b), .point(point_b), .en(en_b), .sign(sign_b),
    .ovf(ovf_b), .upd(upd_b));

  disp_autorange #(.CLK_FREQ(1000), .UPDATE_MS(10), .NCH(4), .DW(40),
                   .FRAC_DIGITS(5), .DIGITS(DIG)) u_c (
    .sys_clk(clk), .sys_rst(rst_c), .ch_data(ch_c), .ch_sel(ch_sel),
    .signed_mode(signed_mode), .hold(hold), .sample_now(sample_now),
    .data(data_c), .point(point_c), .en(en_c), .sign(sign_c),
    .ovf(ovf_c), .upd(upd_c));

  typedef struct {
    int              cnt;
    int              busy;
    longint unsigned pd;
    logic [5:0]      pp;
    bit              ps, po;
    longint unsigned d;
    logic [5:0]      pt;
    bit              en, sg, ov, upd;
  } ms_t;

  ms_t ma, mb, mc;
  int  errors = 0;
  int  checks = 0;
  int  n_upd_a = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Display value from the rules: |x|, then shed fraction digits.
  function automatic void conv(input longint unsigned w, input bit sgn,
                               input int frac, input int dw,
                               output longint unsigned d,
                               output logic [5:0] pt, output bit sg,
                               output bit ov, output int k);
    longint unsigned mag, lim, p;
    bit neg;
    int f;
    neg = sgn && w[dw-1];
    mag = neg ? ((64'd1 << dw) - w) : w;
    p = 1;
    for (int i = 0; i < (neg ? DIG - 1 : DIG); i++) p = p * 10;
    lim = p - 1;
    f = frac;
    k = 0;
    while (mag > lim && f > 0) begin
      mag = mag / 10;
      f--;
      k++;
    end
    ov = mag > lim;
    d  = ov ? lim : mag;
    sg = neg && d != 0;
    pt = (f == 0) ? 6'd0 : 6'(1 << f);
  endfunction

  function automatic ms_t step(input ms_t s, input bit rst, input bit sn,
                               input bit hd, input longint unsigned w,
                               input bit sgn, input int frac,
                               input int dw);
    ms_t n;
    bit tk, trig, sg, ov;
    longint unsigned d;
    logic [5:0] pt;
    int k;
    n = s;
    if (rst) begin
      n.cnt = 0; n.busy = 0; n.d = 0; n.pt = 0;
      n.en = 0; n.sg = 0; n.ov = 0; n.upd = 0;
      return n;
    end
    tk = (s.cnt == P - 1);
    trig = (tk || sn) && !hd && s.busy == 0;
    n.upd = 0;
    if (s.busy > 0) begin
      n.busy = s.busy - 1;
      if (n.busy == 0) begin
        n.d = s.pd; n.pt = s.pp; n.sg = s.ps; n.ov = s.po;
        n.en = 1; n.upd = 1;
      end
    end
    if (trig) begin
      conv(w, sgn, frac, dw, d, pt, sg, ov, k);
      n.pd = d; n.pp = pt; n.ps = sg; n.po = ov;
      n.busy = k + 1;
    end
    n.cnt = (tk || sn) ? 0 : s.cnt + 1;
    return n;
  endfunction

  task automatic chk_inst(input string nm, input ms_t m,
                          input logic [31:0] d, input logic [5:0] pt,
                          input logic e, input logic sg,
                          input logic ov, input logic up);
    chk({nm, ".data"}, 64'(d), m.d);
    chk({nm, ".point"}, 64'(pt), 64'(m.pt));
    chk({nm, ".en"}, 64'(e), 64'(m.en));
    chk({nm, ".sign"}, 64'(sg), 64'(m.sg));
    chk({nm, ".ovf"}, 64'(ov), 64'(m.ov));
    chk({nm, ".upd"}, 64'(up), 64'(m.upd));
  endtask

  task automatic cycle();
    ma = step(ma, rst_ab, sample_now, hold, 64'(wab[ch_sel]),
              signed_mode, 0, 32);
    mb = step(mb, rst_ab, sample_now, hold, 64'(wab[ch_sel]),
              signed_mode, 3, 32);
    mc = step(mc, rst_c, sample_now, hold, 64'(wc[ch_sel]),
              signed_mode, 5, 40);
    @(posedge clk);
    @(negedge clk);
    chk_inst("A", ma, data_a, point_a, en_a, sign_a, ovf_a, upd_a);
    chk_inst("B", mb, data_b, point_b, en_b, sign_b, ovf_b, upd_b);
    chk_inst("C", mc, data_c, point_c, en_c, sign_c, ovf_c, upd_c);
    n_upd_a += int'(upd_a);
  endtask

  task automatic pulse();
    sample_now = 1'b1;
    cycle();
    sample_now = 1'b0;
  endtask

  function automatic logic [31:0] rnd32();
    logic [31:0] t;
    case ($urandom_range(0, 5))
      0: t = 32'($urandom_range(0, 999));
      1: t = 32'($urandom_range(999990, 1000010));
      2: t = 32'($urandom_range(99990, 100010));
      3: t = $urandom;
      4: t = -(32'($urandom_range(0, 200000)));
      default: t = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0;
    endcase
    return t;
  endfunction

  function automatic logic [39:0] rnd40();
    logic [39:0] t;
    case ($urandom_range(0, 4))
      0: t = {8'h00, rnd32()};
      1: t = 40'd9_999_999_999 - 40'($urandom_range(0, 5));
      2: t = {8'($urandom), 32'($urandom)};
      3: t = -{8'h00, 32'($urandom_range(0, 9_999_999))};
      default: t = 40'h80_0000_0000;
    endcase
    return t;
  endfunction

  initial begin
    int guard;
    logic [1:0] j;
    rst_ab = 1'b1; rst_c = 1'b1; hold = 1'b0; sample_now = 1'b0;
    signed_mode = 1'b0; ch_sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wab[i] = '0;
      wc[i]  = '0;
    end
    wab[0] = 32'd123456;
    repeat (2) cycle();
    rst_ab = 1'b0; rst_c = 1'b0;

    // First tick converts channel 0; en stays low until then.
    repeat (14) cycle();
    chk("A.first_data", 64'(data_a), 64'd123456);
    chk("A.first_en", 64'(en_a), 64'd1);

    ch_sel = 2'd1; wab[1] = 32'd1234567;
    pulse();
    repeat (12) cycle();
    chk("B.frac_data", 64'(data_b), 64'd123456);
    chk("B.frac_point", 64'(point_b), 64'b000100);

    signed_mode = 1'b1; ch_sel = 2'd2; wab[2] = -32'd5;
    pulse();
    repeat (12) cycle();
    chk("A.neg5_data", 64'(data_a), 64'd5);
    chk("A.neg5_sign", 64'(sign_a), 64'd1);
    wab[2] = -32'd123456;
    repeat (12) cycle();
    chk("A.negovf_data", 64'(data_a), 64'd99999);
    chk("A.negovf_ovf", 64'(ovf_a), 64'd1);
    wab[2] = 32'd0;
    repeat (12) cycle();
    chk("A.zero_sign", 64'(sign_a), 64'd0);

    signed_mode = 1'b0; ch_sel = 2'd3; wab[3] = 32'hFFFF_FFFB;
    repeat (12) cycle();
    chk("A.uovf_data", 64'(data_a), 64'd999999);
    chk("A.uovf_ovf", 64'(ovf_a), 64'd1);
    chk("A.uovf_sign", 64'(sign_a), 64'd0);

    // Hold blocks every capture, requested or periodic.
    hold = 1'b1; wab[3] = 32'd42; n_upd_a = 0;
    for (int i = 0; i < 30; i++) begin
      sample_now = (i % 7 == 3);
      cycle();
    end
    sample_now = 1'b0;
    chk("A.hold_upd", 64'(n_upd_a), 64'd0);
    chk("A.hold_data", 64'(data_a), 64'd999999);
    hold = 1'b0;
    guard = 0;
    while (ma.cnt != P - 1 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("wait_tick", 64'(ma.cnt), 64'(P - 1));
    n_upd_a = 0;
    pulse();
    repeat (6) cycle();
    chk("A.tick_sn_upd", 64'(n_upd_a), 64'd1);
    chk("A.after_hold", 64'(data_a), 64'd42);

    // Reset C in its third SCALE cycle.
    ch_sel = 2'd0; wc[0] = 40'd9_999_999_999;
    guard = 0;
    while (mc.busy != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    chk("wait_idle", 64'(mc.busy), 64'd0);
    pulse();
    cycle();
    cycle();
    rst_c = 1'b1;
    cycle();
    rst_c = 1'b0;
    chk("C.rst_en", 64'(en_c), 64'd0);
    chk("C.rst_data", 64'(data_c), 64'd0);
    chk("C.rst_upd", 64'(upd_c), 64'd0);
    pulse();
    repeat (8) cycle();
    chk("C.big_data", 64'(data_c), 64'd999999);
    chk("C.big_point", 64'(point_c), 64'b000010);
    chk("C.big_ovf", 64'(ovf_c), 64'd0);

    for (int n = 0; n < 500; n++) begin
      sample_now  = ($urandom_range(0, 7) == 0);
      hold        = ($urandom_range(0, 9) == 0);
      signed_mode = 1'($urandom_range(0, 1));
      ch_sel      = 2'($urandom_range(0, 3));
      rst_ab      = ($urandom_range(0, 63) == 0);
      rst_c       = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) begin
        j = 2'($urandom_range(0, 3));
        wab[j] = rnd32();
        wc[j]  = rnd40();
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
